// File: rtl/hist_eq_pkg.sv
// Shared types and helpers for the histogram-equalisation output stage:
// FSM state encoding, default widths, numerator width and LUT saturation.
package hist_eq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LUT_FETCH = 3'd1,
    LUT_CALC  = 3'd2,
    APPLY     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int LANES_DEF  = 16;
  localparam int PIX_W_DEF  = 8;
  localparam int CDF_W_DEF  = 20;
  localparam int ADDR_W_DEF = 16;

  // Numerator (cdf - cdf_min) * (2^pix_w - 1) needs cdf_w + pix_w bits.
  function automatic int num_w(input int cdf_w, input int pix_w);
    return cdf_w + pix_w;
  endfunction

  function automatic logic [63:0] saturate(input logic [63:0] value,
                                           input logic [63:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/hist_eq_output_engine_if.sv
// Memory-side bus of the output engine: CDF read port, image read port and
// the back-pressured output write port.
interface hist_eq_output_engine_if
  import hist_eq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int CDF_W  = CDF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  localparam int BUS_W = LANES * PIX_W;

  // Reads are fire-and-forget: rd_data is valid exactly one cycle after
  // rd_en. Writes transfer on out_wr_en && out_wr_ready; while out_wr_en is
  // high and ready is low, out_wr_addr/out_wr_data hold steady.
  logic              cdf_rd_en;
  logic [PIX_W-1:0]  cdf_rd_addr;
  logic [CDF_W-1:0]  cdf_rd_data;
  logic              img_rd_en;
  logic [ADDR_W-1:0] img_rd_addr;
  logic [BUS_W-1:0]  img_rd_data;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [BUS_W-1:0]  out_wr_data;
  logic              out_wr_ready;

  modport master (
    output cdf_rd_en, cdf_rd_addr, input cdf_rd_data,
    output img_rd_en, img_rd_addr, input img_rd_data,
    output out_wr_en, out_wr_addr, out_wr_data, input out_wr_ready
  );

  modport slave (
    input cdf_rd_en, cdf_rd_addr, output cdf_rd_data,
    input img_rd_en, img_rd_addr, output img_rd_data,
    input out_wr_en, out_wr_addr, out_wr_data, output out_wr_ready
  );

endinterface

// File: rtl/hist_eq_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so the quotient is ready W cycles after start.
module hist_eq_seq_divider #(
  parameter int W = 28
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] quotient
);
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q, quo_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     src_rem, src_quo, src_div;
  logic [W:0]       shifted;
  logic [W-1:0]     step_rem, step_quo;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_div = start ? divisor : div_q;
    shifted = {src_rem, src_quo[W-1]};
    if (shifted >= {1'b0, src_div}) begin
      step_rem = W'(shifted - {1'b0, src_div});
      step_quo = {src_quo[W-2:0], 1'b1};
    end else begin
      step_rem = shifted[W-1:0];
      step_quo = {src_quo[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      valid <= 1'b0;
    end else if (start) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      div_q <= divisor;
      cnt_q <= CNT_W'(W - 1);
      valid <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt_q <= cnt_q - CNT_W'(1);
      valid <= (cnt_q == CNT_W'(1));
    end else begin
      valid <= 1'b0;
    end
  end

  assign busy     = (cnt_q != '0);
  assign quotient = quo_q;

endmodule

// File: rtl/hist_eq_output_engine.sv
// Histogram-equalisation output stage: builds a remap LUT from the CDF at a
// fixed NUM_W+2 cycles per bin, then streams image words through it.
module hist_eq_output_engine
  import hist_eq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int CDF_W  = CDF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CDF_W-1:0]  cdf_min,
  input  logic [CDF_W-1:0]  divisor,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err_div0,
  output state_t            dbg_state,
  hist_eq_output_engine_if.master mem
);
  localparam int BUS_W   = LANES * PIX_W;
  localparam int NUM_W   = num_w(CDF_W, PIX_W);
  localparam int BINS    = 2 ** PIX_W;
  localparam int PIX_MAX = BINS - 1;
  localparam int CNT_W   = $clog2(NUM_W + 1);

  state_t state_q, state_d;

  logic [CDF_W-1:0]  cdf_min_q, divisor_q;
  logic [ADDR_W-1:0] num_words_q, src_base_q, dst_base_q;
  logic [ADDR_W-1:0] rd_idx_q, wr_idx_q;
  logic [PIX_W-1:0]  bin_q;
  logic [CNT_W-1:0]  calc_cnt_q;
  logic              bypass_q, rd_pending_q;
  logic [PIX_W-1:0]  lut [BINS];

  logic [BUS_W-1:0]  fifo_mem [2];
  logic              fifo_wr_ptr_q, fifo_rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic              cdf_rd_en_c, img_rd_en_c, out_wr_en_c;
  logic              calc_first, calc_last, bypass_now, div_start;
  logic              div_busy, div_valid, push, pop, last_wr, can_issue;
  logic [NUM_W-1:0]  div_diff, div_num, div_quot;
  logic [PIX_W-1:0]  lut_val;
  logic [2:0]        occ;
  logic [BUS_W-1:0]  mapped_word;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = (num_words == '0) ? DONE : LUT_FETCH;
      LUT_FETCH: state_d = LUT_CALC;
      LUT_CALC:  if (calc_last) state_d = (&bin_q) ? APPLY : LUT_FETCH;
      APPLY:     if (last_wr) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    cdf_rd_en_c = 1'b0;
    img_rd_en_c = 1'b0;
    case (state_q)
      LUT_FETCH: begin busy = 1'b1; cdf_rd_en_c = 1'b1; end
      LUT_CALC:  busy = 1'b1;
      APPLY: begin
        busy        = 1'b1;
        img_rd_en_c = (rd_idx_q < num_words_q) && can_issue;
      end
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------- LUT build ----------------
  assign calc_first = (state_q == LUT_CALC) && (calc_cnt_q == '0);
  assign calc_last  = (state_q == LUT_CALC) && (calc_cnt_q == CNT_W'(NUM_W));
  assign bypass_now = (mem.cdf_rd_data <= cdf_min_q) || (divisor_q == '0);
  assign div_diff   = NUM_W'(mem.cdf_rd_data) - NUM_W'(cdf_min_q);
  assign div_num    = div_diff * NUM_W'(PIX_MAX);
  assign div_start  = calc_first && !bypass_now && !div_busy;
  assign lut_val    = (bypass_q || !div_valid) ? '0
                    : PIX_W'(saturate(64'(div_quot), 64'(PIX_MAX)));

  hist_eq_seq_divider #(.W(NUM_W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_num),
    .divisor  (NUM_W'(divisor_q)),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (div_quot)
  );

  always_ff @(posedge clock) begin
    if (calc_last) lut[bin_q] <= lut_val;
  end

  // ---------------- Streaming path ----------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign mapped_word[i*PIX_W +: PIX_W] = lut[mem.img_rd_data[i*PIX_W +: PIX_W]];
  end

  assign out_wr_en_c = (fifo_cnt_q != '0);
  assign push        = rd_pending_q;
  assign pop         = out_wr_en_c && mem.out_wr_ready;
  // A write accepted this cycle frees its slot in time for the next read's data.
  assign occ         = 3'(fifo_cnt_q) + 3'(rd_pending_q) - 3'(pop);
  assign can_issue   = (occ < 3'd2);
  assign last_wr     = pop && (wr_idx_q == num_words_q - ADDR_W'(1));

  always_ff @(posedge clock) begin
    if (push) fifo_mem[fifo_wr_ptr_q] <= mapped_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cdf_min_q     <= '0;
      divisor_q     <= '0;
      num_words_q   <= '0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      bin_q         <= '0;
      calc_cnt_q    <= '0;
      bypass_q      <= 1'b0;
      rd_pending_q  <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= '0;
      err_div0      <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        cdf_min_q   <= cdf_min;
        divisor_q   <= divisor;
        num_words_q <= num_words;
        src_base_q  <= src_base;
        dst_base_q  <= dst_base;
        rd_idx_q    <= '0;
        wr_idx_q    <= '0;
        bin_q       <= '0;
        err_div0    <= (divisor == '0);
      end
      calc_cnt_q <= (state_q == LUT_CALC) ? calc_cnt_q + CNT_W'(1) : '0;
      if (calc_first)  bypass_q <= bypass_now;
      if (calc_last)   bin_q    <= bin_q + PIX_W'(1);
      if (img_rd_en_c) rd_idx_q <= rd_idx_q + ADDR_W'(1);
      if (pop)         wr_idx_q <= wr_idx_q + ADDR_W'(1);
      rd_pending_q <= img_rd_en_c;
      if (push) fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      if (pop)  fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Addresses and data are forced to zero whenever their enable is low.
  assign mem.cdf_rd_en   = cdf_rd_en_c;
  assign mem.cdf_rd_addr = cdf_rd_en_c ? bin_q : '0;
  assign mem.img_rd_en   = img_rd_en_c;
  assign mem.img_rd_addr = img_rd_en_c ? src_base_q + rd_idx_q : '0;
  assign mem.out_wr_en   = out_wr_en_c;
  assign mem.out_wr_addr = out_wr_en_c ? dst_base_q + wr_idx_q : '0;
  assign mem.out_wr_data = out_wr_en_c ? fifo_mem[fifo_rd_ptr_q] : '0;

endmodule
